// File: rtl/fan_run_ctrl.sv
// Range-hood fan run controller.
// Decodes the selected mode into a fan drive level. It times the hurricane
// (level 3) phase and the self-clean phase with a 1 s prescaler, and strobes
// timeout_pulse when a timed phase runs out.
// Optional build macro HURRICANE_ONCE_EN: hurricane is allowed once per power-on.
module fan_run_ctrl #(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned HURRICANE_SEC = 60,
  parameter int unsigned CLEAN_SEC     = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  output logic [1:0] fan_level,
  output logic       clean_active,
  output logic [7:0] remaining_sec,
  output logic       timeout_pulse
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax  = PW'(CLK_HZ - 1);
  localparam logic [7:0]    HurLoad   = 8'(HURRICANE_SEC);
  localparam logic [7:0]    CleanLoad = 8'(CLEAN_SEC);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StHurricane,
    StHurExpired,
    StClean,
    StCleanDone
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          sec_tick;
  logic          hur_blocked;

  assign sec_tick = (presc_q == PrescMax);

`ifdef HURRICANE_ONCE_EN
  logic hur_used_q;
  assign hur_blocked = hur_used_q;
`else
  assign hur_blocked = 1'b0;
`endif

  // Mode FSM with registered outputs; reset, then power-off, take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      fan_level     <= 2'd0;
      clean_active  <= 1'b0;
      remaining_sec <= 8'd0;
      timeout_pulse <= 1'b0;
`ifdef HURRICANE_ONCE_EN
      hur_used_q    <= 1'b0;
`endif
    end else if (!machine_state) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      fan_level     <= 2'd0;
      clean_active  <= 1'b0;
      remaining_sec <= 8'd0;
      timeout_pulse <= 1'b0;
`ifdef HURRICANE_ONCE_EN
      // Cleared while off, so the next power-up starts with hurricane available.
      hur_used_q    <= 1'b0;
`endif
    end else begin
      timeout_pulse <= 1'b0;
      case (mode_state)
        3'b001, 3'b010: begin
          state_q       <= StRun;
          presc_q       <= '0;
          fan_level     <= mode_state[1:0];
          clean_active  <= 1'b0;
          remaining_sec <= 8'd0;
        end
        3'b011: begin
          clean_active <= 1'b0;
          if (state_q == StHurricane) begin
            if (sec_tick) begin
              presc_q <= '0;
              if (remaining_sec <= 8'd1) begin
                state_q       <= StHurExpired;
                fan_level     <= 2'd2;
                remaining_sec <= 8'd0;
                timeout_pulse <= 1'b1;
              end else begin
                remaining_sec <= remaining_sec - 8'd1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end else if (state_q == StHurExpired || hur_blocked) begin
            state_q       <= StHurExpired;
            presc_q       <= '0;
            fan_level     <= 2'd2;
            remaining_sec <= 8'd0;
          end else begin
            state_q       <= StHurricane;
            presc_q       <= '0;
            fan_level     <= 2'd3;
            remaining_sec <= HurLoad;
`ifdef HURRICANE_ONCE_EN
            hur_used_q    <= 1'b1;
`endif
          end
        end
        3'b100: begin
          fan_level <= 2'd0;
          if (state_q == StClean) begin
            if (sec_tick) begin
              presc_q <= '0;
              if (remaining_sec <= 8'd1) begin
                state_q       <= StCleanDone;
                clean_active  <= 1'b0;
                remaining_sec <= 8'd0;
                timeout_pulse <= 1'b1;
              end else begin
                remaining_sec <= remaining_sec - 8'd1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end else if (state_q == StCleanDone) begin
            presc_q       <= '0;
            clean_active  <= 1'b0;
            remaining_sec <= 8'd0;
          end else begin
            state_q       <= StClean;
            presc_q       <= '0;
            clean_active  <= 1'b1;
            remaining_sec <= CleanLoad;
          end
        end
        default: begin
          state_q       <= StIdle;
          presc_q       <= '0;
          fan_level     <= 2'd0;
          clean_active  <= 1'b0;
          remaining_sec <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fan_run_ctrl.sv
// Self-checking bench for fan_run_ctrl (CLK_HZ=10, HURRICANE_SEC=3, CLEAN_SEC=5).
// A phase/elapsed-time model predicts every output after every clock edge.
module tb_fan_run_ctrl;

  localparam int CLK  = 10;
  localparam int HSEC = 3;
  localparam int CSEC = 5;

  // Model phases
  localparam int KOff      = 0;
  localparam int KRun      = 1;
  localparam int KHur      = 2;
  localparam int KHurDone  = 3;
  localparam int KClean    = 4;
  localparam int KCleanEnd = 5;

  logic       clk;
  logic       rst;
  logic       machine_state;
  logic [2:0] mode_state;
  logic [1:0] fan_level;
  logic       clean_active;
  logic [7:0] remaining_sec;
  logic       timeout_pulse;

  int n_checks;
  int n_pass;

  int m_kind;
  int m_elapsed;
  int m_level;
  int m_pulse;
  bit m_used;

  fan_run_ctrl #(
    .CLK_HZ       (CLK),
    .HURRICANE_SEC(HSEC),
    .CLEAN_SEC    (CSEC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .machine_state(machine_state),
    .mode_state   (mode_state),
    .fan_level    (fan_level),
    .clean_active (clean_active),
    .remaining_sec(remaining_sec),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Advance the model by one clock edge with the inputs seen at that edge.
  task automatic model_edge(input bit r, input bit ms, input int m);
    m_pulse = 0;
    if (r || !ms) begin
      m_kind = KOff;
      m_used = 1'b0;
    end else if (m == 1 || m == 2) begin
      m_kind  = KRun;
      m_level = m;
    end else if (m == 3) begin
      if (m_kind == KHur) begin
        m_elapsed++;
        if (m_elapsed == HSEC * CLK) begin
          m_kind  = KHurDone;
          m_pulse = 1;
        end
      end else if (m_kind != KHurDone) begin
`ifdef HURRICANE_ONCE_EN
        if (m_used) m_kind = KHurDone;
        else begin
          m_kind = KHur;
          m_elapsed = 0;
          m_used = 1'b1;
        end
`else
        m_kind    = KHur;
        m_elapsed = 0;
`endif
      end
    end else if (m == 4) begin
      if (m_kind == KClean) begin
        m_elapsed++;
        if (m_elapsed == CSEC * CLK) begin
          m_kind  = KCleanEnd;
          m_pulse = 1;
        end
      end else if (m_kind != KCleanEnd) begin
        m_kind    = KClean;
        m_elapsed = 0;
      end
    end else begin
      m_kind = KOff;
    end
  endtask

  function automatic int exp_fan();
    case (m_kind)
      KRun:     return m_level;
      KHur:     return 3;
      KHurDone: return 2;
      default:  return 0;
    endcase
  endfunction

  function automatic int exp_rem();
    if (m_kind == KHur)   return HSEC - m_elapsed / CLK;
    if (m_kind == KClean) return CSEC - m_elapsed / CLK;
    return 0;
  endfunction

  // Drive inputs away from the edge, clock once, then compare against the model.
  task automatic step(input bit r, input bit ms, input int m);
    rst           = r;
    machine_state = ms;
    mode_state    = 3'(m);
    @(posedge clk);
    model_edge(r, ms, m);
    #1;
    check("fan_level", int'(fan_level), exp_fan());
    check("clean_active", int'(clean_active), (m_kind == KClean) ? 1 : 0);
    check("remaining_sec", int'(remaining_sec), exp_rem());
    check("timeout_pulse", int'(timeout_pulse), m_pulse);
  endtask

  task automatic hold(input int n, input int m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, m);
  endtask

  int pulses;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    m_kind    = KOff;
    m_elapsed = 0;
    m_level   = 0;
    m_pulse   = 0;
    m_used    = 1'b0;
    rst           = 1'b1;
    machine_state = 1'b0;
    mode_state    = 3'd0;

    // Reset state
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 3);
    check("rst_fan", int'(fan_level), 0);
    check("rst_rem", int'(remaining_sec), 0);
    check("rst_pulse", int'(timeout_pulse), 0);

    // Hurricane full countdown
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 3);
    check("hur_entry_fan", int'(fan_level), 3);
    check("hur_entry_rem", int'(remaining_sec), 3);
    pulses = 0;
    for (int i = 1; i <= 31; i++) begin
      step(1'b0, 1'b1, 3);
      pulses += int'(timeout_pulse);
      if (i == 9)  check("hur_rem_c9", int'(remaining_sec), 3);
      if (i == 10) check("hur_rem_c10", int'(remaining_sec), 2);
      if (i == 20) check("hur_rem_c20", int'(remaining_sec), 1);
      if (i == 30) check("hur_pulse_c30", int'(timeout_pulse), 1);
      if (i == 31) check("hur_expired_fan", int'(fan_level), 2);
    end
    check("hur_pulse_count", pulses, 1);

    // Self-clean full run, then held done until standby
    hold(2, 0);
    step(1'b0, 1'b1, 4);
    check("clean_entry_active", int'(clean_active), 1);
    check("clean_entry_rem", int'(remaining_sec), 5);
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b1, 4);
      if (i == 49) check("clean_rem_c49", int'(remaining_sec), 1);
      if (i == 50) check("clean_pulse_c50", int'(timeout_pulse), 1);
    end
    hold(5, 4);
    check("clean_done_active", int'(clean_active), 0);
    hold(2, 0);

    // Abort hurricane at cycle 15, then re-enter (after a power cycle)
    step(1'b0, 1'b0, 0);
    hold(16, 3);
    step(1'b0, 1'b1, 2);
    check("abort_fan", int'(fan_level), 2);
    check("abort_pulse", int'(timeout_pulse), 0);
    step(1'b0, 1'b1, 3);
`ifdef HURRICANE_ONCE_EN
    check("once_second_fan", int'(fan_level), 2);
    check("once_second_rem", int'(remaining_sec), 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 3);
    check("once_after_pwr_rem", int'(remaining_sec), 3);
`else
    check("reentry_rem", int'(remaining_sec), 3);
`endif

    // Power-off mid-clean at remaining 2
    hold(1, 0);
    hold(31, 4);
    check("clean_rem2", int'(remaining_sec), 2);
    step(1'b0, 1'b0, 4);
    check("pwroff_active", int'(clean_active), 0);
    check("pwroff_rem", int'(remaining_sec), 0);

    // Reset mid-hurricane
    step(1'b0, 1'b1, 3);
    hold(12, 3);
    step(1'b1, 1'b1, 3);
    check("rstmid_fan", int'(fan_level), 0);
    check("rstmid_rem", int'(remaining_sec), 0);

    // Reserved mode code
    hold(3, 1);
    step(1'b0, 1'b1, 6);
    check("mode110_fan", int'(fan_level), 0);

    // Randomised segments
    for (int s = 0; s < 70; s++) begin
      int r;
      int len;
      int m;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        len = int'($urandom_range(1, 3));
        for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      end else if (r < 15) begin
        len = int'($urandom_range(1, 5));
        for (int i = 0; i < len; i++) step(1'b0, 1'b0, int'($urandom_range(0, 7)));
      end else begin
        case ($urandom_range(0, 9))
          0: m = 0;
          1: m = 1;
          2: m = 2;
          3, 4, 5: m = 3;
          6, 7, 8: m = 4;
          default: m = int'($urandom_range(5, 7));
        endcase
        len = int'($urandom_range(1, 70));
        hold(len, m);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
